// File: rtl/img_preproc_seq.sv
// Acquisition sequencer for the camera-link preprocessing pipeline.
// Runs a commanded number of frames, interleaving background frames in diff
// mode, and flushes the pipeline on start, on completion and on abort/error.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, abort                one-cycle host commands
//   frame_num, diff_mode,       run setup, sampled on an accepted start
//   bg_every
//   frame_store, frame_type_o   frame-committed pulse and its type tag
//   fifo_overflow ..            pipeline error inputs (honoured in RUN only)
//   ext_trig_overflow
//   init_txn, diff_en,          pipeline control
//   wr2ddr_en, frame_type_i
//   busy, done, err, err_code,  host status
//   frames_done
module img_preproc_seq #(
  parameter int unsigned FLUSH_CYCLES   = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd200_000_000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] frame_num,
  input  logic             diff_mode,
  input  logic [7:0]       bg_every,
  input  logic             frame_store,
  input  logic [1:0]       frame_type_o,
  input  logic             fifo_overflow,
  input  logic             unexpected_data,
  input  logic             unexpected_tlast,
  input  logic             ext_trig_overflow,
  output logic             init_txn,
  output logic             diff_en,
  output logic             wr2ddr_en,
  output logic [1:0]       frame_type_i,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] frames_done
);

  localparam int unsigned     PH_W       = $clog2(2 * FLUSH_CYCLES + 1);
  localparam logic [PH_W-1:0] FLUSH_LAST = PH_W'(FLUSH_CYCLES - 1);
  localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(2 * FLUSH_CYCLES - 1);
  localparam logic [31:0]     WD_LAST    = TIMEOUT_CYCLES - 32'd1;
  localparam logic [1:0]      FT_BG      = 2'b00;
  localparam logic [1:0]      FT_FG      = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_RUN, S_DRAIN, S_ABORT
  } state_t;

  state_t           state_q, state_n;
  logic [PH_W-1:0]  ph_q, ph_n;     // cycle count within FLUSH/DRAIN/ABORT
  logic [31:0]      wd_q, wd_n;     // cycles since last frame_store in RUN
  logic [7:0]       bg_q, bg_n;     // background counter
  logic [CNT_W-1:0] num_q, num_n;
  logic             dm_q, dm_n;
  logic [7:0]       bge_q, bge_n;

  logic             init_n, diff_n, wr_n, busy_n, done_n, err_n;
  logic [1:0]       ft_n;
  logic [2:0]       code_n;
  logic [CNT_W-1:0] fd_n;
  logic [CNT_W-1:0] fd_inc;
  logic             wd_expire;
  logic             type_mismatch;
  logic [2:0]       cause;

  // Error cause in priority order; 0 means no error this cycle.
  always_comb begin
    wd_expire     = (wd_q >= WD_LAST) && !frame_store;
    type_mismatch = frame_store && (frame_type_o != frame_type_i);
    fd_inc        = frames_done + CNT_W'(1);
    if (fifo_overflow)          cause = 3'd1;
    else if (unexpected_data)   cause = 3'd2;
    else if (unexpected_tlast)  cause = 3'd3;
    else if (ext_trig_overflow) cause = 3'd4;
    else if (wd_expire)         cause = 3'd6;
    else if (type_mismatch)     cause = 3'd5;
    else                        cause = 3'd0;
  end

  // Next state, counters, and output values derived from the next state.
  always_comb begin
    state_n = state_q;
    ph_n    = ph_q;
    wd_n    = wd_q;
    bg_n    = bg_q;
    num_n   = num_q;
    dm_n    = dm_q;
    bge_n   = bge_q;
    err_n   = err;
    code_n  = err_code;
    fd_n    = frames_done;
    ft_n    = frame_type_i;
    done_n  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (frame_num == '0) begin
            done_n = 1'b1;
          end else begin
            num_n   = frame_num;
            dm_n    = diff_mode;
            bge_n   = bg_every;
            err_n   = 1'b0;
            code_n  = 3'd0;
            fd_n    = '0;
            bg_n    = 8'd0;
            ph_n    = '0;
            state_n = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        if (abort) begin
          ph_n    = '0;
          state_n = S_ABORT;
        end else if (ph_q == FLUSH_LAST) begin
          wd_n    = 32'd0;
          state_n = S_RUN;
        end else begin
          ph_n = ph_q + PH_W'(1);
        end
      end

      S_RUN: begin
        if (frame_store) begin
          fd_n = fd_inc;
          wd_n = 32'd0;
          // bg_every==0 parks the counter at 1 after the first frame
          if (bge_q == 8'd0)               bg_n = 8'd1;
          else if (bg_q == bge_q - 8'd1)   bg_n = 8'd0;
          else                             bg_n = bg_q + 8'd1;
        end else if (wd_q != '1) begin
          wd_n = wd_q + 32'd1;
        end

        if (cause != 3'd0) begin
          if (!err) begin
            err_n  = 1'b1;
            code_n = cause;
          end
          ph_n    = '0;
          state_n = S_ABORT;
        end else if (abort) begin
          ph_n    = '0;
          state_n = S_ABORT;
        end else if (frame_store && (fd_inc == num_q)) begin
          ph_n    = '0;
          state_n = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (abort) begin
          ph_n    = '0;
          state_n = S_ABORT;
        end else if (ph_q == DRAIN_LAST) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          ph_n = ph_q + PH_W'(1);
        end
      end

      S_ABORT: begin
        if (ph_q == FLUSH_LAST) state_n = S_IDLE;
        else                    ph_n    = ph_q + PH_W'(1);
      end

      default: state_n = S_IDLE;
    endcase

    init_n = (state_n == S_FLUSH) || (state_n == S_ABORT);
    wr_n   = (state_n == S_RUN);
    diff_n = ((state_n == S_RUN) || (state_n == S_DRAIN)) ? dm_n : 1'b0;
    busy_n = (state_n != S_IDLE);
    // Type of the upcoming frame; held outside FLUSH/RUN
    if ((state_n == S_FLUSH) || (state_n == S_RUN))
      ft_n = (dm_n && (bg_n == 8'd0)) ? FT_BG : FT_FG;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ph_q         <= '0;
      wd_q         <= 32'd0;
      bg_q         <= 8'd0;
      num_q        <= '0;
      dm_q         <= 1'b0;
      bge_q        <= 8'd0;
      init_txn     <= 1'b0;
      diff_en      <= 1'b0;
      wr2ddr_en    <= 1'b0;
      frame_type_i <= 2'b00;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= 3'd0;
      frames_done  <= '0;
    end else begin
      state_q      <= state_n;
      ph_q         <= ph_n;
      wd_q         <= wd_n;
      bg_q         <= bg_n;
      num_q        <= num_n;
      dm_q         <= dm_n;
      bge_q        <= bge_n;
      init_txn     <= init_n;
      diff_en      <= diff_n;
      wr2ddr_en    <= wr_n;
      frame_type_i <= ft_n;
      busy         <= busy_n;
      done         <= done_n;
      err          <= err_n;
      err_code     <= code_n;
      frames_done  <= fd_n;
    end
  end

endmodule

// File: tb/tb_img_preproc_seq.sv
// Self-checking bench for img_preproc_seq: directed scenarios plus randomized
// runs, checked every cycle against a behavioural model of the sequencer.
module tb_img_preproc_seq;

  localparam int F  = 16;
  localparam int TO = 100;
  localparam int CW = 16;

  localparam int M_IDLE  = 0;
  localparam int M_FLUSH = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;
  localparam int M_ABORT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic [CW-1:0] frame_num = '0;
  logic          diff_mode = 1'b0;
  logic [7:0]    bg_every = 8'd0;
  logic          frame_store = 1'b0;
  logic [1:0]    frame_type_o = 2'b00;
  logic          fifo_overflow = 1'b0, unexpected_data = 1'b0;
  logic          unexpected_tlast = 1'b0, ext_trig_overflow = 1'b0;
  logic          init_txn, diff_en, wr2ddr_en, busy, done, err;
  logic [1:0]    frame_type_i;
  logic [2:0]    err_code;
  logic [CW-1:0] frames_done;

  int nvec = 0;
  int nerr = 0;

  img_preproc_seq #(
    .FLUSH_CYCLES(F), .TIMEOUT_CYCLES(32'(TO)), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_num(frame_num), .diff_mode(diff_mode), .bg_every(bg_every),
    .frame_store(frame_store), .frame_type_o(frame_type_o),
    .fifo_overflow(fifo_overflow), .unexpected_data(unexpected_data),
    .unexpected_tlast(unexpected_tlast), .ext_trig_overflow(ext_trig_overflow),
    .init_txn(init_txn), .diff_en(diff_en), .wr2ddr_en(wr2ddr_en),
    .frame_type_i(frame_type_i), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_mode, m_left, m_num, m_bge, m_ref, cyc;
  bit   m_dm;
  logic e_init, e_diff, e_wr, e_busy, e_done, e_err;
  logic [1:0] e_ft;
  logic [2:0] e_code;
  int   e_fd;

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_num = 0; m_bge = 0; m_ref = 0; m_dm = 0; cyc = 0;
    e_init = 0; e_diff = 0; e_wr = 0; e_busy = 0; e_done = 0; e_err = 0;
    e_ft = 2'b00; e_code = 3'd0; e_fd = 0;
  endtask

  task automatic go_abort();
    m_mode = M_ABORT;
    m_left = F;
  endtask

  task automatic model_step();
    int cause;
    bit expire, mism, bgz;
    e_done = 0;
    case (m_mode)
      M_IDLE: if (start) begin
        if (frame_num == 0) e_done = 1;
        else begin
          m_num = int'(frame_num); m_dm = diff_mode; m_bge = int'(bg_every);
          e_err = 0; e_code = 0; e_fd = 0;
          m_mode = M_FLUSH; m_left = F;
        end
      end
      M_FLUSH: if (abort) go_abort();
        else begin
          m_left--;
          if (m_left == 0) begin m_mode = M_RUN; m_ref = cyc + 1; end
        end
      M_RUN: begin
        expire = !frame_store && ((cyc - m_ref) >= TO - 1);
        mism   = frame_store && (frame_type_o != e_ft);
        cause  = fifo_overflow ? 1 : unexpected_data ? 2 : unexpected_tlast ? 3 :
                 ext_trig_overflow ? 4 : expire ? 6 : mism ? 5 : 0;
        if (frame_store) begin e_fd++; m_ref = cyc + 1; end
        if (cause != 0) begin
          if (!e_err) begin e_err = 1; e_code = 3'(cause); end
          go_abort();
        end else if (abort) go_abort();
        else if (frame_store && e_fd == m_num) begin m_mode = M_DRAIN; m_left = 2 * F; end
      end
      M_DRAIN: if (abort) go_abort();
        else begin
          m_left--;
          if (m_left == 0) begin m_mode = M_IDLE; e_done = 1; end
        end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
    endcase
    cyc++;
    e_init = (m_mode == M_FLUSH) || (m_mode == M_ABORT);
    e_wr   = (m_mode == M_RUN);
    e_diff = ((m_mode == M_RUN) || (m_mode == M_DRAIN)) && m_dm;
    e_busy = (m_mode != M_IDLE);
    if (m_mode == M_FLUSH || m_mode == M_RUN) begin
      // background frame whenever the committed count is a multiple of the period
      bgz  = (m_bge == 0) ? (e_fd == 0) : ((e_fd % m_bge) == 0);
      e_ft = (m_dm && bgz) ? 2'b00 : 2'b01;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    chk("init_txn", 32'(init_txn), 32'(e_init));
    chk("diff_en", 32'(diff_en), 32'(e_diff));
    chk("wr2ddr_en", 32'(wr2ddr_en), 32'(e_wr));
    chk("frame_type_i", 32'(frame_type_i), 32'(e_ft));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    chk("err_code", 32'(err_code), 32'(e_code));
    chk("frames_done", 32'(frames_done), 32'(CW'(e_fd)));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_in();
    start = 0; abort = 0; frame_store = 0; frame_type_o = 2'b00;
    fifo_overflow = 0; unexpected_data = 0; unexpected_tlast = 0; ext_trig_overflow = 0;
  endtask

  task automatic do_start(input int n, input bit dm, input int bge);
    frame_num = CW'(n); diff_mode = dm; bg_every = 8'(bge); start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!e_wr && n < 200) begin tick(); n++; end
    if (!e_wr) chk("wait_run_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (e_busy && n < 500) begin tick(); n++; end
    if (e_busy) chk("wait_idle_timeout", 32'(n), 32'd0);
    tick();
  endtask

  task automatic send_frame(input int gap);
    repeat (gap) tick();
    frame_store = 1; frame_type_o = e_ft;
    tick();
    frame_store = 0;
  endtask

  task automatic random_drive();
    int n = 0;
    while (e_busy && n < 600) begin
      frame_store       = e_wr && ($urandom_range(0, 2) == 0);
      frame_type_o      = ($urandom_range(0, 24) == 0) ? ~e_ft : e_ft;
      fifo_overflow     = ($urandom_range(0, 299) == 0);
      unexpected_data   = ($urandom_range(0, 299) == 0);
      unexpected_tlast  = ($urandom_range(0, 299) == 0);
      ext_trig_overflow = ($urandom_range(0, 299) == 0);
      abort             = ($urandom_range(0, 199) == 0);
      start             = ($urandom_range(0, 39) == 0);
      frame_num         = CW'($urandom_range(1, 9));
      tick();
      n++;
    end
    clear_in();
    if (e_busy) chk("random_timeout", 32'(n), 32'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d miscompares so far", nerr);
    $fatal(1, "timeout");
  end

  // ---------------- scenarios ----------------
  initial begin
    int n;
    bit saw;
    logic [1:0] seq [5];
    logic [1:0] exp_seq [5];
    exp_seq = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01};

    clear_in();
    repeat (3) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_init", 32'(init_txn), 32'd0);
    rst_n = 1;
    tick();

    // Normal diff run, bg_every=3
    do_start(5, 1, 3);
    n = 0;
    while (init_txn === 1'b1 && n < 100) begin n++; tick(); end
    chk("flush_len", 32'(n), 32'(F));
    wait_run();
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 4)) tick();
      seq[i] = frame_type_i;
      send_frame(0);
    end
    for (int i = 0; i < 5; i++) chk("diff_type_seq", 32'(seq[i]), 32'(exp_seq[i]));
    n = 1;
    while (done !== 1'b1 && n < 200) begin tick(); n++; end
    chk("done_latency", 32'(n), 32'(2 * F + 1));
    chk("diff_frames_done", 32'(frames_done), 32'd5);
    wait_idle();

    // Non-diff run
    do_start(3, 0, 0);
    wait_run();
    for (int i = 0; i < 3; i++) send_frame($urandom_range(0, 3));
    saw = 0; n = 0;
    while (e_busy && n < 200) begin if (done) saw = 1; tick(); n++; end
    if (done) saw = 1;
    chk("nodiff_done", 32'(saw), 32'd1);
    chk("nodiff_err", 32'(err), 32'd0);
    tick();

    // Error priority: fifo_overflow beats unexpected_tlast
    do_start(4, 1, 2);
    wait_run();
    send_frame(1);
    tick();
    fifo_overflow = 1; unexpected_tlast = 1;
    tick();
    clear_in();
    chk("prio_err", 32'(err), 32'd1);
    chk("prio_code", 32'(err_code), 32'd1);
    n = 0; saw = 0;
    while (init_txn === 1'b1 && n < 100) begin n++; if (done) saw = 1; tick(); end
    chk("abort_flush_len", 32'(n), 32'(F));
    chk("abort_no_done", 32'(saw | done), 32'd0);
    chk("abort_busy_drop", 32'(busy), 32'd0);
    tick();

    // Watchdog: store at cycle 99 reloads, then expiry after 100 idle cycles
    do_start(2, 0, 1);
    wait_run();
    repeat (99) tick();
    send_frame(0);
    chk("wd_reload_no_err", 32'(err), 32'd0);
    n = 0;
    while (err !== 1'b1 && n < 300) begin tick(); n++; end
    chk("wd_expire_cycle", 32'(n), 32'(TO));
    chk("wd_code", 32'(err_code), 32'd6);
    wait_idle();

    // Type mismatch on the background frame
    do_start(3, 1, 2);
    wait_run();
    chk("mism_type_bg", 32'(frame_type_i), 32'd0);
    frame_store = 1; frame_type_o = 2'b01;
    tick();
    clear_in();
    chk("mism_code", 32'(err_code), 32'd5);
    chk("mism_fd", 32'(frames_done), 32'd1);
    wait_idle();

    // Host abort mid-RUN
    do_start(5, 1, 0);
    wait_run();
    send_frame(1);
    send_frame(2);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_init", 32'(init_txn), 32'd1);
    chk("abort_fd", 32'(frames_done), 32'd2);
    chk("abort_err", 32'(err), 32'd0);
    wait_idle();
    chk("abort_fd_kept", 32'(frames_done), 32'd2);

    // frame_num == 0: done pulse only
    do_start(0, 0, 0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    tick();
    chk("zero_done_pulse", 32'(done), 32'd0);

    // start during RUN is ignored
    do_start(2, 1, 1);
    wait_run();
    send_frame(0);
    frame_num = CW'(7); start = 1;
    tick();
    start = 0;
    send_frame(1);
    n = 0;
    while (done !== 1'b1 && n < 200) begin tick(); n++; end
    chk("ignored_start_fd", 32'(frames_done), 32'd2);
    wait_idle();

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      do_start($urandom_range(1, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
      random_drive();
    end

    // Reset asserted mid-FLUSH
    do_start(3, 0, 0);
    repeat (5) tick();
    #1 rst_n = 0;
    #1;
    chk("rst_init", 32'(init_txn), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1;
    tick();
    chk("rst_idle_done", 32'(done), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
